// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the M-extension multiply/divide unit.
// Holds the funct3 op enum, the FSM state enum and sign/kind decode functions.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  function automatic logic is_div(muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(muldiv_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU,
                      OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// One radix-2 iteration on {acc, q}: shift-add multiply or restoring divide.
// Ports: is_div selects step, acc_i/q_i state in, opd_i operand, acc_o/q_o next.
module muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] opd_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] sh;
  logic [XLEN:0] diff;
  logic          ge;

  always_comb begin
    sum  = {1'b0, acc_i}
         + (q_i[0] ? {1'b0, opd_i} : '0);
    sh   = {acc_i, q_i[XLEN-1]};
    diff = sh - {1'b0, opd_i};
    // Remainder stays below the divisor, so a set MSB
    // means the trial subtraction borrowed.
    ge   = ~diff[XLEN];
    if (is_div) begin
      acc_o = ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
      q_o   = {q_i[XLEN-2:0], ge};
    end else begin
      // Multiplier bits drain out of q while the
      // product's low half shifts in from the top.
      acc_o = sum[XLEN:1];
      q_o   = {sum[0], q_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide with valid/ready in and out.
// Ports: clk, rst_n, in_valid/in_ready, op, src_a, src_b, out_valid/out_ready, result, zero, negative, busy.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            negative,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  muldiv_op_e       op_q, op_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  qr_q, qr_d;
  logic [XLEN-1:0]  opd_q, opd_d;
  logic             sg_q, sg_d;
  logic             rs_q, rs_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             vld_q, vld_d;

  muldiv_op_e       op_in;
  logic             a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [XLEN-1:0]  acc_nx, qr_nx;

  assign op_in = muldiv_op_e'(op);

  muldiv_core #(.XLEN(XLEN)) u_core (
    .is_div (is_div(op_q)),
    .acc_i  (acc_q),
    .q_i    (qr_q),
    .opd_i  (opd_q),
    .acc_o  (acc_nx),
    .q_o    (qr_nx)
  );

  // hi/lo: product halves, or remainder/quotient.
  // sg negates product/quotient, rs the remainder.
  function automatic logic [XLEN-1:0] fix(
    muldiv_op_e      o,
    logic [XLEN-1:0] hi,
    logic [XLEN-1:0] lo,
    logic            sg,
    logic            rs
  );
    logic [2*XLEN-1:0] p;
    p = sg ? -{hi, lo} : {hi, lo};
    unique case (1'b1)
      is_rem(o):              return rs ? -hi : hi;
      is_div(o):              return sg ? -lo : lo;
      (o == OP_MUL):          return p[XLEN-1:0];
      default:                return p[2*XLEN-1:XLEN];
    endcase
  endfunction

  always_comb begin
    a_neg = is_signed_a(op_in) & src_a[XLEN-1];
    b_neg = is_signed_b(op_in) & src_b[XLEN-1];
    a_mag = a_neg ? -src_a : src_a;
    b_mag = b_neg ? -src_b : src_b;

    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    qr_d    = qr_q;
    opd_d   = opd_q;
    sg_d    = sg_q;
    rs_d    = rs_q;
    res_d   = res_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    vld_d   = vld_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = op_in;
          if (is_div(op_in) && src_b == '0) begin
            state_d = DONE;
            vld_d   = 1'b1;
            res_d   = is_rem(op_in) ? src_a : '1;
          end else if (is_div(op_in)
                       && is_signed_a(op_in)
                       && src_a == MIN_NEG
                       && src_b == '1) begin
            state_d = DONE;
            vld_d   = 1'b1;
            res_d   = is_rem(op_in) ? '0 : MIN_NEG;
          end else begin
            state_d = CALC;
            cnt_d   = '0;
            acc_d   = '0;
            qr_d    = is_div(op_in) ? a_mag : b_mag;
            opd_d   = is_div(op_in) ? b_mag : a_mag;
            sg_d    = a_neg ^ b_neg;
            rs_d    = a_neg;
          end
        end
      end
      CALC: begin
        acc_d = acc_nx;
        qr_d  = qr_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = DONE;
          vld_d   = 1'b1;
          res_d   = fix(op_q, acc_nx, qr_nx,
                        sg_q, rs_q);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flags are loaded only with a fresh result.
    if (state_d == DONE && state_q != DONE) begin
      zero_d = (res_d == '0);
      neg_d  = res_d[XLEN-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      acc_q   <= '0;
      qr_q    <= '0;
      opd_q   <= '0;
      sg_q    <= 1'b0;
      rs_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      qr_q    <= qr_d;
      opd_q   <= opd_d;
      sg_q    <= sg_d;
      rs_q    <= rs_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = vld_q;
  assign result    = res_q;
  assign zero      = zero_q;
  assign negative  = neg_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit with directed M-extension vectors.
// Stimulus pushes expectations; a negedge monitor pops them on each handshake.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'b000;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        negative;
  logic        busy;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .negative  (negative),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        z;
    logic        n;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   seen = 0;
  bit   hold_bad = 0;
  bit   rdy_bad = 0;
  bit   post_hs = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b",
               name, act, exp);
    end
  endtask

  task automatic chki(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (post_hs) begin
        chk1("valid_drop", out_valid, 1'b0);
        chk1("ready_back", in_ready, 1'b1);
        post_hs = 0;
      end
      if (sb.size() > 0 && in_ready)
        rdy_bad = 1;
      if (out_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got %h expected none",
                   result);
        end else begin
          if (!seen) begin
            chki({sb[0].name, "_lat"},
                 cyc - sb[0].acc + 1, sb[0].lat);
            seen = 1;
          end
          if (result !== sb[0].res) hold_bad = 1;
          if (out_ready) begin
            chk({sb[0].name, "_res"}, result, sb[0].res);
            chk1({sb[0].name, "_zero"}, zero, sb[0].z);
            chk1({sb[0].name, "_neg"}, negative, sb[0].n);
            chk1({sb[0].name, "_hold"}, hold_bad, 1'b0);
            chk1({sb[0].name, "_in_ready_low"},
                 rdy_bad, 1'b0);
            void'(sb.pop_front());
            seen     = 0;
            hold_bad = 0;
            rdy_bad  = 0;
            post_hs  = 1;
          end
        end
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic z,
                       input logic n, input int lat);
    int w;
    exp_t e;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL %s_accept: got timeout expected in_ready",
               name);
      return;
    end
    op       = o;
    src_a    = a;
    src_b    = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scrambled operands must not disturb the running op.
    src_a    = ~a;
    src_b    = ~b;
    e.name = name;
    e.res  = r;
    e.z    = z;
    e.n    = n;
    e.lat  = lat;
    e.acc  = cyc;
    sb.push_back(e);
  endtask

  initial begin
    int w;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk1("rst_zero", zero, 1'b0);
    chk1("rst_neg", negative, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    issue("mul_7x3", 3'b000, 32'd7, 32'd3,
          32'h15, 0, 0, 33);
    issue("mul_min_x2", 3'b000, 32'h80000000, 32'd2,
          32'h0, 1, 0, 33);
    issue("mulh_m1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'h0, 1, 0, 33);
    issue("mulh_m3x5", 3'b001, 32'hFFFFFFFD, 32'd5,
          32'hFFFFFFFF, 0, 1, 33);
    issue("mulhsu_m1", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'hFFFFFFFF, 0, 1, 33);
    issue("mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'hFFFFFFFE, 0, 1, 33);
    issue("div_m7_2", 3'b100, 32'hFFFFFFF9, 32'd2,
          32'hFFFFFFFD, 0, 1, 33);
    issue("rem_m7_2", 3'b110, 32'hFFFFFFF9, 32'd2,
          32'hFFFFFFFF, 0, 1, 33);
    issue("divu_m7_2", 3'b101, 32'hFFFFFFF9, 32'd2,
          32'h7FFFFFFC, 0, 0, 33);
    issue("divu_by0", 3'b101, 32'd5, 32'd0,
          32'hFFFFFFFF, 0, 1, 1);
    issue("remu_by0", 3'b111, 32'd5, 32'd0,
          32'd5, 0, 0, 1);
    issue("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF,
          32'h80000000, 0, 1, 1);
    issue("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF,
          32'h0, 1, 0, 1);

    // Back-pressure: hold result with a competing request.
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    out_ready = 1'b0;
    issue("mul_bp", 3'b000, 32'd6, 32'd7,
          32'd42, 0, 0, 33);
    w = 0;
    while (!out_valid && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk1("bp_valid_seen", out_valid, 1'b1);
    op       = 3'b100;
    src_a    = 32'd9;
    src_b    = 32'd3;
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk1("bp_ready_low", in_ready, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset in the middle of a divide.
    issue("div_aborted", 3'b100, 32'd100, 32'd3,
          32'd33, 0, 0, 33);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    seen     = 0;
    hold_bad = 0;
    rdy_bad  = 0;
    post_hs  = 0;
    @(posedge clk);
    #1;
    chk1("abort_valid", out_valid, 1'b0);
    chk("abort_result", result, 32'h0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    issue("div_100_3", 3'b100, 32'd100, 32'd3,
          32'h21, 0, 0, 33);

    w = 0;
    while (sb.size() > 0 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending expected 0",
               sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit implementing the RISC-V M-extension operations.
- Sits beside the single-cycle ALU in the execute stage and adds multi-cycle arithmetic the ALU lacks.
- Accepts one operation through a valid/ready handshake, runs a radix-2 shift-add multiply or restoring divide over XLEN iterations, then holds the result until it is consumed.
- Produces Zero/Negative flags with the same meaning as the ALU's.

Parameters:
XLEN, 32, operand/result width in bits (>= 8, even)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  operation request
in_ready  output  1  unit can accept an operation
op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_a  input  XLEN  rs1 operand (multiplicand/dividend)
src_b  input  XLEN  rs2 operand (multiplier/divisor)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  XLEN  operation result
zero  output  1  result == 0
negative  output  1  result[XLEN-1]
busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low at an edge): state=IDLE, counter=0, result=0, out_valid=0, zero=0, negative=0, busy=0, in_ready=1 after that edge. Reset mid-operation aborts it; the partial result is never presented.
- States: IDLE, CALC, DONE.
  - IDLE: in_ready=1. An edge with in_valid=1 latches op, the operand magnitudes and the sign flags, then goes to CALC (counter=0).
  - IDLE special case: for a divide/remainder with src_b==0, or with signed overflow (DIV/REM, src_a=100..0, src_b=all-ones), go directly to DONE with the special result.
  - CALC: one iteration per cycle, counter increments. After the XLEN-th iteration, apply the sign correction and go to DONE.
  - DONE: out_valid=1 and result/zero/negative held stable. An edge with out_ready=1 goes to IDLE.
- in_ready=0 in CALC and DONE. There is no same-cycle accept on result consumption; the next accept is possible one cycle later.
- Latency, counted as edges from the accepting edge to out_valid high: normal ops XLEN+1; special cases 1.
- Signed handling:
  - MUL/MULH: both operands signed.
  - MULHSU: src_a signed, src_b unsigned.
  - U-variants: unsigned.
  - The core iterates on magnitudes; the 2*XLEN product is negated when exactly one signed operand is negative.
  - MUL returns product[XLEN-1:0]; MULH* return product[2*XLEN-1:XLEN].
- Division: restoring division on magnitudes.
  - Quotient is negated if the signs differ (signed ops).
  - Remainder takes the sign of the dividend.
  - Truncation is toward zero.
- Special results:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give src_a.
  - Signed overflow: DIV gives 100..0; REM gives 0.
- Inputs are ignored outside IDLE; operand changes during CALC have no effect.
- out_valid deasserts on the edge after the handshake.
- zero and negative are registered together with result.

Decomposition:
- Package muldiv_pkg holds:
  - muldiv_op_e enum (8 funct3 codes)
  - state_e {IDLE, CALC, DONE}
  - is_div/is_signed_a/is_signed_b helper functions
- One sub-module, muldiv_core: the per-iteration datapath, a combinational shift-add/subtract step on {acc, q} selected by a mul/div flag.
- The top level owns the FSM, counter, sign fix-up, special cases and output registers.

Test Plan:
- MUL with src_a=7, src_b=3 (XLEN=32), out_ready=1 -> result=21 (0x15), zero=0, negative=0; out_valid exactly 33 edges after accept; in_ready=0 throughout.
- MULH / MULHSU / MULHU, each with src_a=src_b=0xFFFFFFFF:
  - MULH -> 0x00000000, zero=1
  - MULHSU -> 0xFFFFFFFF, negative=1
  - MULHU -> 0xFFFFFFFE
- DIV and REM with src_a=-7 (0xFFFFFFF9), src_b=2:
  - DIV -> 0xFFFFFFFD (-3), negative=1
  - REM -> 0xFFFFFFFF (-1)
  - DIVU with the same operands -> 0x7FFFFFFC
- Special cases, each with out_valid 1 edge after accept:
  - DIVU 5/0 -> 0xFFFFFFFF
  - REMU 5/0 -> 5
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000, negative=1
  - REM with the same operands -> 0, zero=1
- Back-pressure: MUL 6*7 with out_ready=0 for 5 cycles after out_valid -> result=42 held stable, in_valid ignored (in_ready=0); out_ready=1 -> out_valid drops the next edge, in_ready=1.
- Reset mid-operation: start DIV 100/3, pull rst_n low at iteration 10 -> at the next edge out_valid=0, result=0, busy=0, in_ready=1; a new DIV 100/3 then completes with 33 (0x21).
